axis_split_2x32: RTL
====================

Name: axis_split_2x32

Overview:
- Splits one 64-bit AXI-Stream beat into two independent 32-bit AXI-Stream lanes: lane 0 carries bits [31:0], lane 1 carries bits [63:32].
- Sits on the FFT output side. It unpacks the 64-bit FFT result stream into two 32-bit streams for DMA or downstream consumers.
- Each lane has its own small FIFO, so one lane can stall without corrupting the other.
- Also checks that tlast arrives at the configured frame length.

Parameters:
- DEPTH, 2, entries per lane FIFO. Must be a power of 2 and at least 2.
- FRAME_LEN, 1024, beats per FFT frame. Must be at least 2.
- CNT_W, 10, width of the beat counter. Equals clog2(FRAME_LEN).

Ports:
- aclk  in  1  single clock; all logic is clocked on its rising edge
- aresetn  in  1  asynchronous, active-low reset
- s_axis_tdata  in  64  input beat; {lane1, lane0}
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  input end of frame
- s_axis_tready  out  1  input ready
- m0_axis_tdata  out  32  lane 0 data, from input bits [31:0]
- m0_axis_tvalid  out  1  lane 0 valid
- m0_axis_tlast  out  1  lane 0 end of frame
- m0_axis_tready  in  1  lane 0 ready
- m1_axis_tdata  out  32  lane 1 data, from input bits [63:32]
- m1_axis_tvalid  out  1  lane 1 valid
- m1_axis_tlast  out  1  lane 1 end of frame
- m1_axis_tready  in  1  lane 1 ready
- frame_err  out  1  one-cycle pulse on a tlast mismatch
- frame_err_sticky  out  1  set by any frame_err; cleared only by reset

Behaviour:
- Reset (aresetn=0, asynchronous):
  - both FIFOs empty; all tvalid=0, tlast=0, tdata=0
  - s_axis_tready=0 while reset is asserted; it rises on the first clock edge after release
  - beat counter=0; frame_err=0; frame_err_sticky=0
  - reset mid-frame discards all buffered beats; the next accepted beat is treated as beat 0
- Input ready: s_axis_tready = !full0 && !full1, derived from registered occupancy. There is no combinational path from m*_axis_tready to s_axis_tready.
- Accept (s_axis_tvalid && s_axis_tready at a clock edge):
  - push {tdata[31:0], tlast} into lane 0
  - push {tdata[63:32], tlast} into lane 1
  - both lanes always receive the same number of beats, in the same order
- Lane output:
  - first-word-fall-through: m*_tvalid = !empty; tdata and tlast present the head entry
  - pop on m*_tvalid && m*_tready
  - the two lanes drain independently
- Latency and throughput:
  - an accepted beat appears on both lanes on the next cycle
  - sustained throughput is 1 beat/cycle when both consumers hold tready=1
- Simultaneous push and pop on the same lane: occupancy is unchanged and the data order is preserved.
- Full lane: if either lane is full, the input stalls (tready=0) even if the other lane is empty.
- Empty lane: tvalid=0. Its tdata holds the last value and is don't-care for checking.
- Pointers wrap modulo DEPTH. Occupancy counter is clog2(DEPTH)+1 bits.
- Frame check, evaluated on each accepted beat:
  - expected_last = (cnt == FRAME_LEN-1)
  - mismatch when tlast != expected_last; frame_err pulses 1 cycle after the offending accept and frame_err_sticky is set
  - cnt returns to 0 on accepted tlast=1 or when cnt == FRAME_LEN-1; otherwise it increments
  - data is passed through unchanged on error; the checker never drops or alters beats

Decomposition:
- Package axis_split_pkg:
  - LANE_W=32, BEAT_W=64
  - lane entry type = {logic last, logic [LANE_W-1:0] data}
- Sub-module axis_lane_fifo (params DEPTH, W): synchronous FWFT FIFO with full/empty/occupancy. Instantiated twice.
- The top level holds the ready logic and the frame checker.

Test Plan:
- Reset release, both tready=1: stream beats 0x00000002_00000001, 0x00000004_00000003 -> m0 outputs 0x1, 0x3; m1 outputs 0x2, 0x4; each appears 1 cycle after accept; 1 beat/cycle sustained.
- m1_tready=0, m0_tready=1, DEPTH=2, continuous input -> exactly 2 beats accepted, then s_tready=0; m0 drains 2 words; release m1 -> m1 emits 2 words in order; input resumes.
- Random independent tready on each lane (50%), 4096 beats -> each lane's output sequence equals its half of the input sequence; no loss or duplication.
- FRAME_LEN=4, tlast on beat 3 -> frame_err stays 0; tlast on both lanes aligns with the 4th word.
- FRAME_LEN=4, tlast on beat 1 -> frame_err pulses on the cycle after accept; sticky=1; next frame counted from 0. Missing tlast on beat 3 -> frame_err pulse.
- Assert aresetn low mid-frame with both FIFOs holding data -> all tvalid=0 immediately; after release, buffers are empty, sticky=0, cnt=0.

Source files
------------

// File: rtl/axis_split_pkg.sv
// Shared types for the 64->2x32 AXI-Stream splitter: lane geometry and the
// per-lane FIFO entry layout.
package axis_split_pkg;
  localparam int LANE_W    = 32;
  localparam int NUM_LANES = 2;
  localparam int BEAT_W    = NUM_LANES * LANE_W;

  typedef struct packed {
    logic              last;
    logic [LANE_W-1:0] data;
  } lane_ent_t;
endpackage

// File: rtl/axis_lane_fifo.sv
// First-word-fall-through FIFO for one output lane. The head entry is always
// presented on rdata_o; it is stale (don't-care) while empty.
module axis_lane_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 33
) (
  input  logic         gclk_i,
  input  logic         grst_ni,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_q, rd_q;
  logic [AW:0]             occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge gclk_i or negedge grst_ni) begin
    if (!grst_ni) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_i) rd_q <= rd_q + AW'(1);
      occ_q <= occ_d;
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = (occ_q == (AW+1)'(DEPTH));
  assign empty_o = (occ_q == '0);
endmodule

// File: rtl/axis_split_2x32.sv
// Splits a 64-bit AXI-Stream into two independently drained 32-bit lanes and
// flags frames whose tlast does not land on beat FRAME_LEN-1.
module axis_split_2x32
  import axis_split_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int FRAME_LEN = 1024,
  parameter int CNT_W     = 10
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [BEAT_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [LANE_W-1:0] m0_axis_tdata,
  output logic              m0_axis_tvalid,
  output logic              m0_axis_tlast,
  input  logic              m0_axis_tready,
  output logic [LANE_W-1:0] m1_axis_tdata,
  output logic              m1_axis_tvalid,
  output logic              m1_axis_tlast,
  input  logic              m1_axis_tready,
  output logic              frame_err,
  output logic              frame_err_sticky
);
  lane_ent_t [NUM_LANES-1:0] wr_ent, rd_ent;
  logic [NUM_LANES-1:0]      full, empty, pop, m_ready;
  logic                      accept, rdy_en_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      err_q, err_d, sticky_q, exp_last;

  // Ready depends only on registered occupancy, never on downstream tready.
  assign s_axis_tready = rdy_en_q & ~(|full);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign m_ready       = {m1_axis_tready, m0_axis_tready};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign wr_ent[l] = {s_axis_tlast, s_axis_tdata[l*LANE_W +: LANE_W]};
    assign pop[l]    = ~empty[l] & m_ready[l];

    axis_lane_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(lane_ent_t))
    ) u_fifo (
      .gclk_i  (aclk),
      .grst_ni (aresetn),
      .push_i  (accept),
      .wdata_i (wr_ent[l]),
      .pop_i   (pop[l]),
      .rdata_o (rd_ent[l]),
      .full_o  (full[l]),
      .empty_o (empty[l])
    );
  end

  assign m0_axis_tdata  = rd_ent[0].data;
  assign m0_axis_tvalid = ~empty[0];
  assign m0_axis_tlast  = rd_ent[0].last & ~empty[0];
  assign m1_axis_tdata  = rd_ent[1].data;
  assign m1_axis_tvalid = ~empty[1];
  assign m1_axis_tlast  = rd_ent[1].last & ~empty[1];

  // An early tlast restarts the count so the next frame is judged on its own.
  assign exp_last = (cnt_q == CNT_W'(FRAME_LEN - 1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (accept) begin
      err_d = (s_axis_tlast != exp_last);
      cnt_d = (s_axis_tlast || exp_last) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_en_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      sticky_q <= sticky_q | err_d;
    end
  end

  assign frame_err        = err_q;
  assign frame_err_sticky = sticky_q;
endmodule
